async_fifo_fwft: RTL and testbench



---
 rtl/async_fifo_fwft_pkg.sv | 9 +
 rtl/fifo_dp_ram.sv | 17 +
 rtl/async_fifo_fwft.sv | 74 +++++++
 tb/tb_async_fifo_fwft.sv | 109 ++++++++++
 4 files changed

// File: rtl/async_fifo_fwft_pkg.sv
// async_fifo_fwft_pkg: default parameters and count-width helper for async_fifo_fwft
package async_fifo_fwft_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RESERVE = 8;
  function automatic int cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/fifo_dp_ram.sv
// fifo_dp_ram: simple dual-port RAM, synchronous write, combinational read
module fifo_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/async_fifo_fwft.sv
// async_fifo_fwft: FWFT FIFO, RAM plus output register, reserve-threshold full flag.
// Define ASYNC_FIFO_FWFT_ASSERT_EN to compile simulation assertions.
module async_fifo_fwft
  import async_fifo_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RESERVE    = DEF_RESERVE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  has_data,
  output logic                  empty
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW = cnt_w(ADDR_WIDTH);
  localparam int CAPACITY = DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(CAPACITY - RESERVE);
  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [CW-1:0]         r_ram_count;
  logic                  r_has_data;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [CW-1:0]         w_occ;
  logic                  w_wr, w_load;
  // a same-cycle pop never frees RAM space for the write: both use registered state
  assign w_wr   = wr_en && (r_ram_count < DEPTH_C);
  assign w_load = (r_ram_count != '0) && (!r_has_data || rd_en);
  assign w_occ  = r_ram_count + CW'(r_has_data);
  assign full     = w_occ >= THRESH;
  assign has_data = r_has_data;
  assign empty    = !r_has_data;
  assign rd_data  = r_rd_data;
  fifo_dp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .i_we(w_wr),
    .i_waddr(r_wptr),
    .i_wdata(wr_data),
    .i_raddr(r_rptr),
    .o_rdata(w_ram_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ram_count <= '0;
      r_has_data  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_wptr      <= r_wptr + ADDR_WIDTH'(w_wr);
      r_rptr      <= r_rptr + ADDR_WIDTH'(w_load);
      r_ram_count <= r_ram_count + CW'(w_wr) - CW'(w_load);
      r_has_data  <= w_load ? 1'b1 : (rd_en ? 1'b0 : r_has_data);
      r_rd_data   <= w_load ? w_ram_rdata : r_rd_data;
    end
`ifdef ASYNC_FIFO_FWFT_ASSERT_EN
  if (RESERVE > DEPTH) begin : g_bad_reserve
    $error("RESERVE must not exceed DEPTH");
  end
  a_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && r_ram_count == DEPTH_C))
    else $error("write dropped: RAM full");
  a_underflow: assert property (@(posedge clk) disable iff (rst) !(rd_en && !r_has_data))
    else $error("rd_en with no data");
  a_count: assert property (@(posedge clk) disable iff (rst) r_ram_count <= DEPTH_C)
    else $error("ram_count exceeds DEPTH");
`else
`endif
endmodule

// File: tb/tb_async_fifo_fwft.sv
// tb_async_fifo_fwft: randomized and directed checks against a queue-based reference model
module tb_async_fifo_fwft;
  localparam int DEPTH = 16;
  localparam int CAP = DEPTH + 1;
  localparam int RES = 8;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic full, has_data, empty;
  logic [7:0] rd_data;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];
  bit hv = 1'b0;
  async_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESERVE(RES)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .has_data(has_data), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // storage = everything in q; the head sits in the output register once hv is set
  task automatic step(input bit we, input logic [7:0] d, input bit re);
    int ram;
    bit acc, pop, load;
    wr_en = we; wr_data = d; rd_en = re;
    ram  = q.size() - int'(hv);
    acc  = we && ram < DEPTH;
    pop  = re && hv;
    load = ram > 0 && (!hv || re);
    if (pop) got.push_back(rd_data);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    hv = load ? 1'b1 : (pop ? 1'b0 : hv);
    #1;
    chk("has_data", 32'(has_data), 32'(hv));
    chk("empty", 32'(empty), 32'(!hv));
    chk("full", 32'(full), 32'(q.size() >= CAP - RES));
    if (hv) chk("rd_data", 32'(rd_data), 32'(q[0]));
    wr_en = 1'b0; rd_en = 1'b0;
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, hv);
  endtask
  task automatic burst(input int base);
    got.delete();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(base + i), 1'b0);
      if (i == 7) chk("full_before_9", 32'(full), 32'd0);
      if (i == 8) chk("full_at_9", 32'(full), 32'd1);
    end
    drain(100);
    chk("burst_count", got.size(), 32'd17);
    for (int i = 0; i < got.size(); i++) chk("burst_word", 32'(got[i]), 32'(base + i));
    chk("burst_empty", 32'(empty), 32'd1);
  endtask
  initial begin
    int fc;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_has_data", 32'(has_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    burst(0);
    burst(20);
    step(1'b1, 8'hA5, 1'b0);
    chk("single_n", 32'(has_data), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_n1", 32'(has_data), 32'd1);
    chk("single_data", 32'(rd_data), 32'hA5);
    drain(3);
    got.delete();
    fc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(i), hv);
      if (full) fc++;
    end
    drain(5);
    chk("stream_full", fc, 32'd0);
    chk("stream_count", got.size(), 32'd100);
    for (int i = 0; i < got.size(); i++) chk("stream_word", 32'(got[i]), 32'(i));
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_has_data", 32'(has_data), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); hv = 1'b0; got.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    drain(10);
    chk("arst_count", got.size(), 32'd3);
    for (int i = 0; i < got.size(); i++) chk("arst_word", 32'(got[i]), 32'(8'hC0 + i));
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45) && hv);
    drain(40);
    chk("final_empty", 32'(empty), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
